key_debounce: RTL and testbench
===============================

// Module: key_debounce
// PURPOSE
//  Input-side counterpart of the 7-seg display path. Takes the raw, asynchronous, bouncing DE2
//  KEY pushbuttons (active-low) and produces clean, CLOCK_50-synchronous key events.
//  Events are a debounced level, one-cycle press/release pulses and an auto-repeat pulse.
//  Top level uses these events to drive counters and display logic in place of raw KEY/SW.
// PARAMETERS
//  NUM_KEYS         4         number of independent key channels
//  DEBOUNCE_CYCLES  1000000   stable cycles needed to accept a change (20 ms @ 50 MHz); >=1
//  REPEAT_DELAY     25000000  held cycles from press acceptance to first oREPEAT (0.5 s)
//  REPEAT_RATE      5000000   cycles between later oREPEAT pulses (0.1 s); 0 disables repeat
// PORTS
//  CLOCK_50   in   1         sole clock, all state on posedge
//  RESET      in   1         synchronous, active-high reset
//  KEY        in   NUM_KEYS  raw buttons, active-low, asynchronous to CLOCK_50
//  oPRESSED   out  NUM_KEYS  debounced level, 1 = key held
//  oPRESS     out  NUM_KEYS  1-cycle pulse on accepted press
//  oRELEASE   out  NUM_KEYS  1-cycle pulse on accepted release
//  oREPEAT    out  NUM_KEYS  1-cycle auto-repeat pulse while held
// BEHAVIOUR
//  - Reset (RESET high at posedge): all outputs 0.
//    Sync flops = 1 (released), all counters = 0, every FSM = IDLE.
//    No oRELEASE is emitted for a key held when reset hits.
//  - Sync: 2-flop synchronizer per bit. Internal s = sync output, where s=0 means pressed.
//  - Counters: 32-bit unsigned. Compare against PARAM-1. Cleared on every state transition.
//  - Per-channel FSM (channels fully independent):
//    IDLE      : s==0 -> PRESS_WAIT with cnt=0.
//    PRESS_WAIT: s==1 -> IDLE with cnt=0 (bounce rejected).
//                Else if cnt==DEBOUNCE_CYCLES-1 -> HELD; oPRESS=1 for that cycle; oPRESSED=1.
//                Else cnt++.
//    HELD      : s==1 -> RELEASE_WAIT with cnt=0.
//                Else run the repeat timer rpt: first pulse at rpt==REPEAT_DELAY-1,
//                then every REPEAT_RATE cycles. oREPEAT=1 for one cycle at each; rpt wraps.
//    RELEASE_WAIT: s==0 -> HELD. The repeat timer restarts from 0, with REPEAT_DELAY to go.
//                Else if cnt==DEBOUNCE_CYCLES-1 -> IDLE; oRELEASE=1; oPRESSED=0.
//                Else cnt++.
//  - oPRESSED is 1 in HELD and RELEASE_WAIT.
//  - Latency: KEY stable low first sampled at edge E -> s low at E+1.
//    oPRESS and oPRESSED rise at edge E+1+DEBOUNCE_CYCLES. Release timing is symmetric.
//  - oPRESS, oRELEASE and oREPEAT are registered. They never assert in the same cycle
//    on one channel; oREPEAT never coincides with oPRESS.
//  - REPEAT_RATE==0: oREPEAT stays 0 forever. REPEAT_DELAY==0 is treated as 1.
//  - Reset mid-operation overrides everything in that cycle.
//    A key still held after reset re-qualifies through PRESS_WAIT and yields a fresh oPRESS.
// STRUCTURE
//  - key_debounce_defs.vh: FSM state localparams (IDLE=2'd0, PRESS_WAIT=2'd1, HELD=2'd2,
//    RELEASE_WAIT=2'd3) and the counter width localparam CNT_W=32.
//  - Sub-module key_debounce_chan: one synchronizer + FSM + counters, 1-bit ports.
//  - key_debounce instantiates NUM_KEYS copies in a generate loop and concatenates the outputs.
// TESTING (sim params: DEBOUNCE_CYCLES=8, REPEAT_DELAY=20, REPEAT_RATE=5)
//  1 Reset: RESET=1 for 3 cycles, KEY=4'hF -> all outputs 0. Then KEY[2]=0 during reset
//    and RESET released -> exactly one oPRESS[2], 10 edges after release.
//  2 Clean press: KEY[0] 1->0 sampled at edge E, held -> oPRESS[0]=1 only at E+9,
//    and oPRESSED[0]=1 from E+9.
//  3 Bounce: KEY[1] toggles every 3 cycles for 40 cycles, then stays 1
//    -> no oPRESS/oRELEASE/oREPEAT and oPRESSED[1]=0 throughout.
//  4 Auto-repeat: hold KEY[0] 60 cycles after oPRESS
//    -> oREPEAT[0] at +20, +25, +30 ... +60 (9 pulses).
//    Rerun with REPEAT_RATE=0 -> no pulses.
//  5 Release glitch: in HELD, KEY[0]=1 for 4 cycles, then 0
//    -> no oRELEASE, oPRESSED stays 1, repeat restarts (next oREPEAT 20 cycles after re-entry).
//    Then KEY[0]=1 held -> oRELEASE[0] 9 edges after the first sample of 1.
//  6 Simultaneous: KEY=4'b0000 in one cycle -> oPRESS=4'b1111 in the same cycle.
//    RESET pulsed mid-HELD -> outputs 0 next edge, no oRELEASE.

Source files
------------

// File: rtl/key_debounce_pkg.sv
// Shared types and constants for the pushbutton debouncer: channel FSM states,
// counter width and the terminal-count helper.
package key_debounce_pkg;

  localparam int unsigned CNT_W = 32;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_HELD         = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } key_state_t;

  // Terminal count for a duration in cycles; zero is treated as one.
  function automatic cnt_t last_count(input int unsigned cycles);
    return (cycles == 0) ? cnt_t'(0) : cnt_t'(cycles - 1);
  endfunction

endpackage

// File: rtl/key_debounce_chan.sv
// One pushbutton channel: 2-flop synchronizer, debounce FSM, and the
// press/release/auto-repeat event generators, all registered.
module key_debounce_chan
  import key_debounce_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_RATE     = 5000000
) (
  input  logic clk,
  input  logic reset,
  input  logic key,
  output logic pressed,
  output logic press_pulse,
  output logic release_pulse,
  output logic repeat_pulse
);

  localparam cnt_t DB_LAST   = last_count(DEBOUNCE_CYCLES);
  localparam bit   DB_SINGLE = (DEBOUNCE_CYCLES <= 1);
  localparam cnt_t RD_LAST   = last_count(REPEAT_DELAY);
  localparam cnt_t RR_LAST   = last_count(REPEAT_RATE);
  localparam bit   REP_EN    = (REPEAT_RATE != 0);

  logic [1:0] sync_q;
  logic       s;
  key_state_t state;
  cnt_t       cnt;
  cnt_t       rpt;
  logic       rpt_phase;

  assign s = sync_q[1];

  // The IDLE/HELD sample that first sees the new level counts as the first
  // stable cycle, so the wait states start their count at one.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q        <= 2'b11;
      state         <= ST_IDLE;
      cnt           <= '0;
      rpt           <= '0;
      rpt_phase     <= 1'b0;
      pressed       <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      repeat_pulse  <= 1'b0;
    end else begin
      sync_q        <= {sync_q[0], key};
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      repeat_pulse  <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (!s) begin
            if (DB_SINGLE) begin
              state       <= ST_HELD;
              press_pulse <= 1'b1;
              pressed     <= 1'b1;
              cnt         <= '0;
              rpt         <= '0;
              rpt_phase   <= 1'b0;
            end else begin
              state <= ST_PRESS_WAIT;
              cnt   <= cnt_t'(1);
            end
          end
        end

        ST_PRESS_WAIT: begin
          if (s) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else if (cnt == DB_LAST) begin
            state       <= ST_HELD;
            press_pulse <= 1'b1;
            pressed     <= 1'b1;
            cnt         <= '0;
            rpt         <= '0;
            rpt_phase   <= 1'b0;
          end else begin
            cnt <= cnt + cnt_t'(1);
          end
        end

        ST_HELD: begin
          if (s) begin
            if (DB_SINGLE) begin
              state         <= ST_IDLE;
              release_pulse <= 1'b1;
              pressed       <= 1'b0;
              cnt           <= '0;
            end else begin
              state <= ST_RELEASE_WAIT;
              cnt   <= cnt_t'(1);
            end
          end else if (REP_EN) begin
            // First pulse after the hold delay, then one every repeat period.
            if (rpt == (rpt_phase ? RR_LAST : RD_LAST)) begin
              repeat_pulse <= 1'b1;
              rpt          <= '0;
              rpt_phase    <= 1'b1;
            end else begin
              rpt <= rpt + cnt_t'(1);
            end
          end
        end

        ST_RELEASE_WAIT: begin
          if (!s) begin
            state     <= ST_HELD;
            cnt       <= '0;
            rpt       <= '0;
            rpt_phase <= 1'b0;
          end else if (cnt == DB_LAST) begin
            state         <= ST_IDLE;
            release_pulse <= 1'b1;
            pressed       <= 1'b0;
            cnt           <= '0;
          end else begin
            cnt <= cnt + cnt_t'(1);
          end
        end

        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/key_debounce.sv
// Debounces NUM_KEYS active-low raw pushbuttons into clean CLOCK_50-synchronous
// level, press, release and auto-repeat events, one independent channel per key.
module key_debounce
  import key_debounce_pkg::*;
#(
  parameter int unsigned NUM_KEYS        = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_RATE     = 5000000
) (
  input  logic                CLOCK_50,
  input  logic                RESET,
  input  logic [NUM_KEYS-1:0] KEY,
  output logic [NUM_KEYS-1:0] oPRESSED,
  output logic [NUM_KEYS-1:0] oPRESS,
  output logic [NUM_KEYS-1:0] oRELEASE,
  output logic [NUM_KEYS-1:0] oREPEAT
);

  for (genvar g = 0; g < int'(NUM_KEYS); g++) begin : g_chan
    key_debounce_chan #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_RATE     (REPEAT_RATE)
    ) u_chan (
      .clk           (CLOCK_50),
      .reset         (RESET),
      .key           (KEY[g]),
      .pressed       (oPRESSED[g]),
      .press_pulse   (oPRESS[g]),
      .release_pulse (oRELEASE[g]),
      .repeat_pulse  (oREPEAT[g])
    );
  end

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce with short debounce/repeat timings; a second
// instance with REPEAT_RATE=0 covers the repeat-disabled configuration.
module tb_key_debounce;

  logic       CLOCK_50 = 1'b0;
  logic       RESET;
  logic [3:0] KEY;
  logic [3:0] oPRESSED, oPRESS, oRELEASE, oREPEAT;
  logic [3:0] nr_pressed, nr_press, nr_release, nr_repeat;

  int tests = 0;
  int fails = 0;

  always #5 CLOCK_50 = ~CLOCK_50;

  key_debounce #(
    .NUM_KEYS(4), .DEBOUNCE_CYCLES(8), .REPEAT_DELAY(20), .REPEAT_RATE(5)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .RESET    (RESET),
    .KEY      (KEY),
    .oPRESSED (oPRESSED),
    .oPRESS   (oPRESS),
    .oRELEASE (oRELEASE),
    .oREPEAT  (oREPEAT)
  );

  key_debounce #(
    .NUM_KEYS(4), .DEBOUNCE_CYCLES(8), .REPEAT_DELAY(20), .REPEAT_RATE(0)
  ) dut_nr (
    .CLOCK_50 (CLOCK_50),
    .RESET    (RESET),
    .KEY      (KEY),
    .oPRESSED (nr_pressed),
    .oPRESS   (nr_press),
    .oRELEASE (nr_release),
    .oREPEAT  (nr_repeat)
  );

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  function automatic logic [15:0] ev();
    return {oPRESSED, oPRESS, oRELEASE, oREPEAT};
  endfunction

  function automatic logic [15:0] ev_nr();
    return {nr_pressed, nr_press, nr_release, nr_repeat};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h (pressed,press,release,repeat)", tag, obs, exp);
    end
  endtask

  initial begin
    int reps;
    RESET = 1'b1;
    KEY   = 4'hF;

    // Reset holds everything at zero
    repeat (3) tick();
    chk("reset_outputs", ev(), 16'h0);
    chk("reset_outputs_norep", ev_nr(), 16'h0);

    // Key held across reset release re-qualifies: press on 10th edge after release
    KEY[2] = 1'b0;
    tick();
    chk("reset_with_key_low", ev(), 16'h0);
    RESET = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      chk("post_reset_press", ev(),
          {(i >= 10) ? 4'b0100 : 4'b0000, (i == 10) ? 4'b0100 : 4'b0000, 4'b0000, 4'b0000});
    end

    KEY = 4'hF;
    for (int i = 1; i <= 12; i++) begin
      tick();
      chk("key2_release", ev(),
          {(i < 10) ? 4'b0100 : 4'b0000, 4'b0000, (i == 10) ? 4'b0100 : 4'b0000, 4'b0000});
    end

    // Clean press on KEY[0]: press pulse at E+9
    KEY = 4'hE;
    for (int i = 1; i <= 10; i++) begin
      tick();
      chk("clean_press", ev(),
          {(i >= 10) ? 4'b0001 : 4'b0000, (i == 10) ? 4'b0001 : 4'b0000, 4'b0000, 4'b0000});
    end

    // Auto-repeat at +20, +25 ... +60; disabled instance stays silent
    reps = 0;
    for (int j = 1; j <= 62; j++) begin
      tick();
      chk("auto_repeat", ev(),
          {4'b0001, 4'b0000, 4'b0000,
           (j >= 20 && ((j - 20) % 5) == 0) ? 4'b0001 : 4'b0000});
      chk("repeat_disabled", {12'h0, nr_repeat}, 16'h0);
      if (oREPEAT[0]) reps++;
    end
    chk("repeat_count", 16'(reps), 16'd9);

    // Release glitch of 4 cycles: stays pressed, repeat restarts from re-entry
    KEY = 4'hF;
    for (int t = 1; t <= 4; t++) begin
      tick();
      chk("glitch_high", ev(), {4'b0001, 4'b0000, 4'b0000, 4'b0000});
    end
    KEY = 4'hE;
    for (int k = 1; k <= 26; k++) begin
      tick();
      chk("glitch_reentry", ev(),
          {4'b0001, 4'b0000, 4'b0000, (k == 23) ? 4'b0001 : 4'b0000});
    end

    // Real release: one repeat still due before the FSM sees it, release at E+9
    KEY = 4'hF;
    for (int m = 1; m <= 12; m++) begin
      tick();
      chk("key0_release", ev(),
          {(m < 10) ? 4'b0001 : 4'b0000, 4'b0000,
           (m == 10) ? 4'b0001 : 4'b0000, (m == 2) ? 4'b0001 : 4'b0000});
    end

    // Bounce on KEY[1]: 3-cycle runs never qualify
    for (int c = 0; c < 40; c++) begin
      KEY = {2'b11, ((c / 3) % 2 == 0) ? 1'b0 : 1'b1, 1'b1};
      tick();
      chk("bounce", ev(), 16'h0);
    end
    KEY = 4'hF;
    for (int c = 0; c < 12; c++) begin
      tick();
      chk("bounce_settle", ev(), 16'h0);
    end

    // All keys at once
    KEY = 4'h0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      chk("all_press", ev(),
          {(i >= 10) ? 4'hF : 4'h0, (i == 10) ? 4'hF : 4'h0, 4'h0, 4'h0});
    end
    repeat (3) tick();
    chk("all_held", ev(), {4'hF, 4'h0, 4'h0, 4'h0});

    // Reset mid-HELD: zero next edge, no release, fresh press afterwards
    RESET = 1'b1;
    tick();
    chk("mid_reset", ev(), 16'h0);
    RESET = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      chk("requalify", ev(),
          {(i >= 10) ? 4'hF : 4'h0, (i == 10) ? 4'hF : 4'h0, 4'h0, 4'h0});
    end

    KEY = 4'hF;
    for (int i = 1; i <= 12; i++) begin
      tick();
      chk("all_release", ev(),
          {(i < 10) ? 4'hF : 4'h0, 4'h0, (i == 10) ? 4'hF : 4'h0, 4'h0});
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
